// File: rtl/ad5676_dac_cmd_arbiter.sv
// Packet/chain-granular arbiter sharing one ad5676 controller command port between
// two FWFT command FIFOs, with per-source packet counters and a starvation flag.
module ad5676_dac_cmd_arbiter #(
  parameter int DAC_WR_PAYLOAD = 4,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [31:0]          src0_word,
  input  logic                 src0_empty,
  output logic                 src0_rd_en,
  input  logic [31:0]          src1_word,
  input  logic                 src1_empty,
  output logic                 src1_rd_en,
  output logic [31:0]          cmd_word,
  output logic                 cmd_buf_empty,
  input  logic                 cmd_word_rd_en,
  input  logic                 dac_fault,
  output logic [1:0]           grant,
  output logic                 mid_pkt_starve,
  output logic [CNT_WIDTH-1:0] src0_pkt_cnt,
  output logic [CNT_WIDTH-1:0] src1_pkt_cnt
);

  localparam int WL_W = $clog2(DAC_WR_PAYLOAD + 1);

  typedef enum logic [1:0] {
    ARB  = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 last_grant_q, last_grant_d;  // 0 = src0, 1 = src1
  logic [WL_W-1:0]      words_left_q, words_left_d;
  logic                 chain_q, chain_d;
  logic [CNT_WIDTH-1:0] cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                 starve_q, starve_d;

  logic        own_empty;
  logic [31:0] own_word;
  logic        pop;

  // Zero-latency passthrough of the granted FIFO head
  always_comb begin
    own_word  = 32'd0;
    own_empty = 1'b1;
    case (state_q)
      OWN0: begin
        own_word  = src0_word;
        own_empty = src0_empty;
      end
      OWN1: begin
        own_word  = src1_word;
        own_empty = src1_empty;
      end
      default: ;
    endcase
  end

  assign grant          = {state_q == OWN1, state_q == OWN0};
  assign cmd_word       = own_word;
  assign cmd_buf_empty  = own_empty;
  assign pop            = cmd_word_rd_en & ~own_empty;
  assign src0_rd_en     = cmd_word_rd_en & grant[0] & ~src0_empty;
  assign src1_rd_en     = cmd_word_rd_en & grant[1] & ~src1_empty;
  assign mid_pkt_starve = starve_q;
  assign src0_pkt_cnt   = cnt0_q;
  assign src1_pkt_cnt   = cnt1_q;

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    words_left_d = words_left_q;
    chain_d      = chain_q;
    cnt0_d       = cnt0_q;
    cnt1_d       = cnt1_q;
    starve_d     = starve_q;

    if (dac_fault) begin
      state_d      = ARB;
      words_left_d = '0;
      chain_d      = 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (!src0_empty && (src1_empty || last_grant_q)) begin
            state_d = OWN0;
          end else if (!src1_empty) begin
            state_d = OWN1;
          end
        end
        OWN0, OWN1: begin
          if (own_empty && ((words_left_q != '0) || chain_q)) begin
            starve_d = 1'b1;
          end
          if (pop) begin
            // Any pop with no payload outstanding is a header
            if (words_left_q == '0) begin
              words_left_d = (own_word[31:30] == 2'b01) ? WL_W'(DAC_WR_PAYLOAD) : '0;
              chain_d      = own_word[27];
            end else begin
              words_left_d = words_left_q - WL_W'(1);
            end
            if (words_left_d == '0) begin
              if (state_q == OWN0) begin
                if (cnt0_q != '1) cnt0_d = cnt0_q + CNT_WIDTH'(1);
              end else begin
                if (cnt1_q != '1) cnt1_d = cnt1_q + CNT_WIDTH'(1);
              end
              if (!chain_d) begin
                state_d      = ARB;
                last_grant_d = (state_q == OWN1);
              end
            end
          end
        end
        default: state_d = ARB;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ARB;
      last_grant_q <= 1'b1;
      words_left_q <= '0;
      chain_q      <= 1'b0;
      cnt0_q       <= '0;
      cnt1_q       <= '0;
      starve_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      words_left_q <= words_left_d;
      chain_q      <= chain_d;
      cnt0_q       <= cnt0_d;
      cnt1_q       <= cnt1_d;
      starve_q     <= starve_d;
    end
  end

endmodule

// File: tb/tb_ad5676_dac_cmd_arbiter.sv
// Bench for ad5676_dac_cmd_arbiter: hand-derived vector table plus randomized
// traffic checked against a packet-level reference model driving queue FIFOs.
module tb_ad5676_dac_cmd_arbiter;
  localparam int PAYLOAD = 4;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic [31:0]   src0_word = '0, src1_word = '0;
  logic          src0_empty = 1'b1, src1_empty = 1'b1;
  logic          src0_rd_en, src1_rd_en;
  logic [31:0]   cmd_word;
  logic          cmd_buf_empty;
  logic          cmd_word_rd_en = 1'b0;
  logic          dac_fault = 1'b0;
  logic [1:0]    grant;
  logic          mid_pkt_starve;
  logic [CW-1:0] src0_pkt_cnt, src1_pkt_cnt;

  always #5 clk = ~clk;

  ad5676_dac_cmd_arbiter #(.DAC_WR_PAYLOAD(PAYLOAD), .CNT_WIDTH(CW)) dut (
    .clk(clk), .resetn(resetn),
    .src0_word(src0_word), .src0_empty(src0_empty), .src0_rd_en(src0_rd_en),
    .src1_word(src1_word), .src1_empty(src1_empty), .src1_rd_en(src1_rd_en),
    .cmd_word(cmd_word), .cmd_buf_empty(cmd_buf_empty), .cmd_word_rd_en(cmd_word_rd_en),
    .dac_fault(dac_fault), .grant(grant), .mid_pkt_starve(mid_pkt_starve),
    .src0_pkt_cnt(src0_pkt_cnt), .src1_pkt_cnt(src1_pkt_cnt)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] q0[$];
  logic [31:0] q1[$];

  // Reference model: owner 0 = none, 1 = src0, 2 = src1
  int m_owner, m_last, m_left, m_cnt0, m_cnt1;
  bit m_chain, m_starve;
  bit e_rd0, e_rd1;

  typedef struct {
    bit          rst;
    bit          p0v;
    logic [31:0] p0w;
    bit          p1v;
    logic [31:0] p1w;
    bit          rd;
    bit          flt;
    logic [1:0]  g;
    int          c0;
    int          c1;
    bit          st;
  } vec_t;
  vec_t vt[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = 0; m_last = 1; m_left = 0; m_chain = 0;
    m_cnt0 = 0; m_cnt1 = 0; m_starve = 0;
  endtask

  task automatic drive_srcs();
    src0_empty = (q0.size() == 0);
    src1_empty = (q1.size() == 0);
    src0_word  = src0_empty ? 32'd0 : q0[0];
    src1_word  = src1_empty ? 32'd0 : q1[0];
  endtask

  task automatic model_check(input bit rd);
    logic [1:0]  eg;
    logic [31:0] ew;
    bit          ee;
    eg = (m_owner == 1) ? 2'b01 : (m_owner == 2) ? 2'b10 : 2'b00;
    ee = (m_owner == 1) ? (q0.size() == 0) : (m_owner == 2) ? (q1.size() == 0) : 1'b1;
    ew = 32'd0;
    if (m_owner == 1 && q0.size() > 0) ew = q0[0];
    if (m_owner == 2 && q1.size() > 0) ew = q1[0];
    e_rd0 = rd && (m_owner == 1) && (q0.size() > 0);
    e_rd1 = rd && (m_owner == 2) && (q1.size() > 0);
    chk("grant", 32'(grant), 32'(eg));
    chk("cmd_word", cmd_word, ew);
    chk("cmd_buf_empty", 32'(cmd_buf_empty), 32'(ee));
    chk("src0_rd_en", 32'(src0_rd_en), 32'(e_rd0));
    chk("src1_rd_en", 32'(src1_rd_en), 32'(e_rd1));
    chk("mid_pkt_starve", 32'(mid_pkt_starve), 32'(m_starve));
    chk("src0_pkt_cnt", 32'(src0_pkt_cnt), 32'(m_cnt0));
    chk("src1_pkt_cnt", 32'(src1_pkt_cnt), 32'(m_cnt1));
  endtask

  task automatic model_edge(input bit rst, input bit flt);
    bit          has0, has1, has;
    logic [31:0] w;
    has0 = (q0.size() > 0);
    has1 = (q1.size() > 0);
    w = 32'd0;
    if (e_rd0) w = q0.pop_front();
    if (e_rd1) w = q1.pop_front();
    if (rst) begin
      model_reset();
    end else if (flt) begin
      m_owner = 0; m_left = 0; m_chain = 0;
    end else if (m_owner == 0) begin
      if (has0 && (!has1 || m_last == 1)) m_owner = 1;
      else if (has1) m_owner = 2;
    end else begin
      has = (m_owner == 1) ? has0 : has1;
      if (!has && (m_left > 0 || m_chain)) m_starve = 1;
      if (e_rd0 || e_rd1) begin
        if (m_left == 0) begin
          m_left  = (w[31:30] == 2'b01) ? PAYLOAD : 0;
          m_chain = w[27];
        end else begin
          m_left--;
        end
        if (m_left == 0) begin
          if (m_owner == 1) m_cnt0 = (m_cnt0 == CNT_MAX) ? CNT_MAX : m_cnt0 + 1;
          else              m_cnt1 = (m_cnt1 == CNT_MAX) ? CNT_MAX : m_cnt1 + 1;
          if (!m_chain) begin
            m_last  = m_owner - 1;
            m_owner = 0;
          end
        end
      end
    end
  endtask

  task automatic front(input bit rst, input bit rd, input bit flt);
    resetn         = !rst;
    cmd_word_rd_en = rd;
    dac_fault      = flt;
    drive_srcs();
    @(negedge clk);
    model_check(rd);
  endtask

  task automatic back(input bit rst, input bit flt);
    @(posedge clk);
    model_edge(rst, flt);
    #1;
  endtask

  task automatic add(input bit rst, input bit p0v, input logic [31:0] p0w,
                     input bit p1v, input logic [31:0] p1w, input bit rd, input bit flt,
                     input logic [1:0] g, input int c0, input int c1, input bit st);
    vec_t v;
    v.rst = rst; v.p0v = p0v; v.p0w = p0w; v.p1v = p1v; v.p1w = p1w;
    v.rd = rd; v.flt = flt; v.g = g; v.c0 = c0; v.c1 = c1; v.st = st;
    vt.push_back(v);
  endtask

  task automatic idle(input bit rd, input bit flt, input logic [1:0] g,
                      input int c0, input int c1, input bit st);
    add(0, 0, 32'd0, 0, 32'd0, rd, flt, g, c0, c1, st);
  endtask

  task automatic rst_row();
    add(1, 0, 32'd0, 0, 32'd0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    w = $urandom;
    w[27] = ($urandom % 5 == 0);
    return w;
  endfunction

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;

    // Single src0 NO_OP
    rst_row();
    add(0, 1, 32'h0000_0010, 0, 32'd0, 0, 0, 2'b00, 0, 0, 0);
    idle(1, 0, 2'b01, 0, 0, 0);
    idle(0, 0, 2'b00, 1, 0, 0);
    // DAC_WR header + 4 payload words locks out src1
    rst_row();
    add(0, 1, 32'h4000_0000, 1, 32'h0000_0020, 0, 0, 2'b00, 0, 0, 0);
    add(0, 1, 32'h1111_1111, 0, 32'd0, 0, 0, 2'b01, 0, 0, 0);
    add(0, 1, 32'h2222_2222, 0, 32'd0, 0, 0, 2'b01, 0, 0, 0);
    add(0, 1, 32'h3333_3333, 0, 32'd0, 0, 0, 2'b01, 0, 0, 0);
    add(0, 1, 32'h4444_4444, 0, 32'd0, 1, 0, 2'b01, 0, 0, 0);
    repeat (4) idle(1, 0, 2'b01, 0, 0, 0);
    idle(0, 0, 2'b00, 1, 0, 0);
    idle(1, 0, 2'b10, 1, 0, 0);
    idle(0, 0, 2'b00, 1, 1, 0);
    // src1 chain (type 10 with bit27, then NO_OP) ahead of src0
    rst_row();
    add(0, 0, 32'd0, 1, 32'h8800_0000, 0, 0, 2'b00, 0, 0, 0);
    add(0, 1, 32'h0000_0010, 1, 32'h0000_0030, 0, 0, 2'b10, 0, 0, 0);
    idle(1, 0, 2'b10, 0, 0, 0);
    idle(1, 0, 2'b10, 0, 1, 0);
    idle(0, 0, 2'b00, 0, 2, 0);
    idle(1, 0, 2'b01, 0, 2, 0);
    idle(0, 0, 2'b00, 1, 2, 0);
    // Mid-packet starvation, then completion
    rst_row();
    add(0, 1, 32'h4000_0000, 0, 32'd0, 0, 0, 2'b00, 0, 0, 0);
    add(0, 1, 32'h0000_00A1, 0, 32'd0, 1, 0, 2'b01, 0, 0, 0);
    add(0, 1, 32'h0000_00A2, 0, 32'd0, 1, 0, 2'b01, 0, 0, 0);
    idle(1, 0, 2'b01, 0, 0, 0);
    idle(1, 0, 2'b01, 0, 0, 0);
    idle(0, 0, 2'b01, 0, 0, 1);
    add(0, 1, 32'h0000_00A3, 0, 32'd0, 1, 0, 2'b01, 0, 0, 1);
    add(0, 1, 32'h0000_00A4, 0, 32'd0, 1, 0, 2'b01, 0, 0, 1);
    idle(0, 0, 2'b00, 1, 0, 1);
    // Fault after two payload pops; counters and flag hold
    add(0, 1, 32'h4000_0000, 0, 32'd0, 0, 0, 2'b00, 1, 0, 1);
    add(0, 1, 32'h0000_00B1, 0, 32'd0, 1, 0, 2'b01, 1, 0, 1);
    add(0, 1, 32'h0000_00B2, 0, 32'd0, 1, 0, 2'b01, 1, 0, 1);
    add(0, 1, 32'h0000_00B3, 0, 32'd0, 1, 0, 2'b01, 1, 0, 1);
    idle(0, 1, 2'b01, 1, 0, 1);
    add(0, 0, 32'd0, 1, 32'h4000_0000, 0, 0, 2'b00, 1, 0, 1);
    add(0, 0, 32'd0, 1, 32'h0000_00C1, 1, 0, 2'b10, 1, 0, 1);
    add(0, 0, 32'd0, 1, 32'h0000_00C2, 1, 0, 2'b10, 1, 0, 1);
    add(0, 0, 32'd0, 1, 32'h0000_00C3, 1, 0, 2'b10, 1, 0, 1);
    add(0, 0, 32'd0, 1, 32'h0000_00C4, 1, 0, 2'b10, 1, 0, 1);
    idle(1, 0, 2'b10, 1, 0, 1);
    idle(0, 1, 2'b00, 1, 1, 1);
    idle(1, 0, 2'b00, 1, 1, 1);
    idle(1, 0, 2'b01, 1, 1, 1);
    idle(0, 0, 2'b00, 2, 1, 1);
    // Round-robin over three NO_OPs per source
    rst_row();
    add(0, 1, 32'h0000_0010, 1, 32'h0000_0020, 0, 0, 2'b00, 0, 0, 0);
    add(0, 1, 32'h0000_0011, 1, 32'h0000_0021, 0, 0, 2'b01, 0, 0, 0);
    add(0, 1, 32'h0000_0012, 1, 32'h0000_0022, 0, 0, 2'b01, 0, 0, 0);
    idle(1, 0, 2'b01, 0, 0, 0);
    idle(0, 0, 2'b00, 1, 0, 0);
    idle(1, 0, 2'b10, 1, 0, 0);
    idle(0, 0, 2'b00, 1, 1, 0);
    idle(1, 0, 2'b01, 1, 1, 0);
    idle(0, 0, 2'b00, 2, 1, 0);
    idle(1, 0, 2'b10, 2, 1, 0);
    idle(0, 0, 2'b00, 2, 2, 0);
    idle(1, 0, 2'b01, 2, 2, 0);
    idle(0, 0, 2'b00, 3, 2, 0);
    idle(1, 0, 2'b10, 3, 2, 0);
    idle(0, 0, 2'b00, 3, 3, 0);

    foreach (vt[i]) begin
      if (vt[i].rst) begin
        q0.delete();
        q1.delete();
      end
      if (vt[i].p0v) q0.push_back(vt[i].p0w);
      if (vt[i].p1v) q1.push_back(vt[i].p1w);
      front(vt[i].rst, vt[i].rd, vt[i].flt);
      if (!vt[i].rst) begin
        chk($sformatf("row%0d_grant", i), 32'(grant), 32'(vt[i].g));
        chk($sformatf("row%0d_cnt0", i), 32'(src0_pkt_cnt), 32'(vt[i].c0));
        chk($sformatf("row%0d_cnt1", i), 32'(src1_pkt_cnt), 32'(vt[i].c1));
        chk($sformatf("row%0d_starve", i), 32'(mid_pkt_starve), 32'(vt[i].st));
      end
      back(vt[i].rst, vt[i].flt);
    end

    // Randomized traffic against the reference model
    for (int n = 0; n < 4000; n++) begin
      bit r, rd, flt;
      r   = (n == 0) || ($urandom % 1500 == 0);
      rd  = 0;
      flt = 0;
      if (r) begin
        q0.delete();
        q1.delete();
      end else begin
        if (q0.size() < 6 && $urandom % 3 == 0) q0.push_back(rand_word());
        if (q1.size() < 6 && $urandom % 3 == 0) q1.push_back(rand_word());
        rd  = ($urandom % 4 != 0);
        flt = ($urandom % 150 == 0);
      end
      front(r, rd, flt);
      back(r, flt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
